// File: rtl/instr_decoder.sv
// Command/data byte decoder between spi_bridge and the PWM register file.
// Optional illegal-address check: define INSTR_ADDR_CHECK_EN (adds addr_err).
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   cs_n, byte_sync  async SPI-domain inputs, synchronised here
//   data_in          received byte, sampled on the synced byte_sync rise
//   data_out         byte returned to spi_bridge for MISO
//   read, write      one-cycle register-file strobes
//   addr, hi_sel     register address and upper-byte select
//   data_write       write data, valid with write
//   data_read        register-file read data
//   addr_err         sticky illegal-address flag (macro builds only)
module instr_decoder #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 6'h14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic              hi_sel,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read
`ifdef INSTR_ADDR_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  localparam logic [1:0] CMD     = 2'd0;
  localparam logic [1:0] DATA    = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;

  logic [SYNC_STAGES-1:0] bs_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic bs_prev;
  logic cs_prev;
  logic bs_s;
  logic cs_s;
  logic byte_valid;
  logic cs_rise;
  logic take;
  logic addr_bad;

  logic [1:0] state;
  logic       is_rd;
  logic       bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      bs_q    <= '0;
      cs_q    <= '1;
      bs_prev <= 1'b0;
      cs_prev <= 1'b1;
    end else begin
      bs_q    <= {bs_q[SYNC_STAGES-2:0], byte_sync};
      cs_q    <= {cs_q[SYNC_STAGES-2:0], cs_n};
      bs_prev <= bs_s;
      cs_prev <= cs_s;
    end
  end

  assign bs_s       = bs_q[SYNC_STAGES-1];
  assign cs_s       = cs_q[SYNC_STAGES-1];
  assign byte_valid = bs_s & ~bs_prev;
  assign cs_rise    = cs_s & ~cs_prev;
  // Deselected bytes are dropped; this also makes a cs_n rise
  // win over a coincident byte.
  assign take       = byte_valid & ~cs_s;

`ifdef INSTR_ADDR_CHECK_EN
  assign addr_bad = data_in[ADDR_W-1:0] > MAX_ADDR;
`else
  assign addr_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CMD;
      is_rd      <= 1'b0;
      bad        <= 1'b0;
      data_out   <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      addr       <= '0;
      hi_sel     <= 1'b0;
      data_write <= '0;
`ifdef INSTR_ADDR_CHECK_EN
      addr_err   <= 1'b0;
`endif
    end else begin
      read  <= 1'b0;
      write <= 1'b0;
      unique case (state)
        CMD: begin
          if (take) begin
            addr   <= data_in[ADDR_W-1:0];
            hi_sel <= data_in[6];
            is_rd  <= data_in[7];
            bad    <= addr_bad;
`ifdef INSTR_ADDR_CHECK_EN
            if (addr_bad)
              addr_err <= 1'b1;
`endif
            if (data_in[7]) begin
              read  <= ~addr_bad;
              state <= RD_WAIT;
            end else begin
              state <= DATA;
            end
          end
        end
        RD_WAIT: begin
          // On abort the earlier capture is kept.
          if (cs_rise) begin
            state <= CMD;
          end else begin
            data_out <= bad ? '1 : data_read;
            state    <= DATA;
          end
        end
        DATA: begin
          if (cs_rise) begin
            state <= CMD;
          end else if (take) begin
            if (!is_rd && !bad) begin
              data_write <= data_in;
              write      <= 1'b1;
            end
            state <= CMD;
          end
        end
        default: state <= CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder.
// Strobes are tallied by a monitor; each task checks its own scenario.
module tb_instr_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       byte_sync = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic       hi_sel;
  logic [7:0] data_write;
  logic [7:0] data_read = 8'h00;
`ifdef INSTR_ADDR_CHECK_EN
  logic       addr_err;
`endif

  int checks = 0;
  int errors = 0;
  int rd_cnt, wr_cnt;
  logic [5:0] rd_addr, wr_addr;
  logic       rd_hi, wr_hi;
  logic [7:0] wr_data;

  instr_decoder dut (
    .clk(clk), .rst(rst), .cs_n(cs_n),
    .byte_sync(byte_sync), .data_in(data_in),
    .data_out(data_out), .read(read), .write(write),
    .addr(addr), .hi_sel(hi_sel),
    .data_write(data_write), .data_read(data_read)
`ifdef INSTR_ADDR_CHECK_EN
    , .addr_err(addr_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (read) begin
        rd_cnt++;
        rd_addr = addr;
        rd_hi = hi_sel;
      end
      if (write) begin
        wr_cnt++;
        wr_addr = addr;
        wr_hi = hi_sel;
        wr_data = data_write;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rd_cnt = 0;
    wr_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in = b;
    byte_sync = 1'b1;
    tick(6);
    byte_sync = 1'b0;
    tick(6);
  endtask

  task automatic frame_on();
    cs_n = 1'b0;
    tick(4);
  endtask

  task automatic frame_off();
    cs_n = 1'b1;
    tick(6);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    checks++;
    if ({data_out, read, write, addr, hi_sel, data_write} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {data_out, read, write, addr, hi_sel, data_write});
    end
`ifdef INSTR_ADDR_CHECK_EN
    checks++;
    if (addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_addr_err got %b want 0", addr_err);
    end
`endif
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_write();
    clr();
    frame_on();
    send_byte(8'h05);
    send_byte(8'hA5);
    frame_off();
    checks++;
    if (wr_cnt !== 1) begin
      errors++;
      $display("FAIL wr_count got %0d want 1", wr_cnt);
    end
    checks++;
    if ({wr_hi, wr_addr, wr_data} !== {1'b0, 6'h05, 8'hA5}) begin
      errors++;
      $display("FAIL wr_fields got %b/%h/%h want 0/05/a5",
               wr_hi, wr_addr, wr_data);
    end
    checks++;
    if (rd_cnt !== 0) begin
      errors++;
      $display("FAIL wr_no_read got %0d want 0", rd_cnt);
    end
  endtask

  task automatic test_read();
    int first;
    int nrd;
    logic [7:0] d5;
    clr();
    data_read = 8'h3C;
    frame_on();
    first = -1;
    nrd = 0;
    d5 = 8'h00;
    data_in = 8'h80;
    byte_sync = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (read) begin
        if (first < 0) first = i;
        nrd++;
      end
      if (i == 5) d5 = data_out;
    end
    #1;
    byte_sync = 1'b0;
    tick(6);
    send_byte(8'h00);
    frame_off();
    checks++;
    if (first !== 4 || nrd !== 1) begin
      errors++;
      $display("FAIL rd_latency got %0d/%0d want 4/1", first, nrd);
    end
    checks++;
    if (d5 !== 8'h3C) begin
      errors++;
      $display("FAIL rd_data_out got %h want 3c", d5);
    end
    checks++;
    if (rd_cnt !== 1 || rd_addr !== 6'h00 || wr_cnt !== 0) begin
      errors++;
      $display("FAIL rd_strobes got %0d/%h/%0d want 1/00/0",
               rd_cnt, rd_addr, wr_cnt);
    end
  endtask

  task automatic test_abort();
    clr();
    frame_on();
    send_byte(8'h4A);
    checks++;
    if (addr !== 6'h0A || hi_sel !== 1'b1) begin
      errors++;
      $display("FAIL ab_cmd got %h/%b want 0a/1", addr, hi_sel);
    end
    frame_off();
    checks++;
    if (wr_cnt !== 0) begin
      errors++;
      $display("FAIL ab_no_write got %0d want 0", wr_cnt);
    end
    frame_on();
    send_byte(8'h01);
    send_byte(8'h77);
    frame_off();
    checks++;
    if (wr_cnt !== 1 || wr_addr !== 6'h01 || wr_data !== 8'h77) begin
      errors++;
      $display("FAIL ab_next got %0d/%h/%h want 1/01/77",
               wr_cnt, wr_addr, wr_data);
    end
    checks++;
    if (data_out !== 8'h3C) begin
      errors++;
      $display("FAIL dout_hold got %h want 3c", data_out);
    end
  endtask

  task automatic test_back_to_back();
    clr();
    data_read = 8'h5A;
    frame_on();
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h83);
    send_byte(8'h00);
    frame_off();
    checks++;
    if (wr_cnt !== 1 || wr_addr !== 6'h02 || wr_data !== 8'h11) begin
      errors++;
      $display("FAIL b2b_write got %0d/%h/%h want 1/02/11",
               wr_cnt, wr_addr, wr_data);
    end
    checks++;
    if (rd_cnt !== 1 || rd_addr !== 6'h03 || rd_hi !== 1'b0) begin
      errors++;
      $display("FAIL b2b_read got %0d/%h/%b want 1/03/0",
               rd_cnt, rd_addr, rd_hi);
    end
    checks++;
    if (data_out !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_dout got %h want 5a", data_out);
    end
  endtask

  task automatic test_reset_mid();
    clr();
    frame_on();
    send_byte(8'h05);
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    checks++;
    if ({data_out, read, write, addr, hi_sel, data_write} !== 25'd0) begin
      errors++;
      $display("FAIL mid_reset got %h want 0",
               {data_out, read, write, addr, hi_sel, data_write});
    end
    #1;
    rst = 1'b0;
    tick(4);
    send_byte(8'h06);
    send_byte(8'h99);
    frame_off();
    checks++;
    if (wr_cnt !== 1 || wr_addr !== 6'h06 || wr_data !== 8'h99) begin
      errors++;
      $display("FAIL mid_new_cmd got %0d/%h/%h want 1/06/99",
               wr_cnt, wr_addr, wr_data);
    end
  endtask

`ifdef INSTR_ADDR_CHECK_EN
  task automatic test_addr_check();
    clr();
    data_read = 8'h12;
    frame_on();
    send_byte(8'h3F);
    send_byte(8'h55);
    checks++;
    if (wr_cnt !== 0 || addr_err !== 1'b1) begin
      errors++;
      $display("FAIL chk_write got %0d/%b want 0/1", wr_cnt, addr_err);
    end
    send_byte(8'hBF);
    send_byte(8'h00);
    frame_off();
    checks++;
    if (rd_cnt !== 0 || data_out !== 8'hFF) begin
      errors++;
      $display("FAIL chk_read got %0d/%h want 0/ff", rd_cnt, data_out);
    end
    frame_on();
    send_byte(8'h01);
    send_byte(8'h22);
    frame_off();
    checks++;
    if (addr_err !== 1'b1 || wr_cnt !== 1) begin
      errors++;
      $display("FAIL chk_sticky got %b/%0d want 1/1", addr_err, wr_cnt);
    end
    test_reset();
  endtask
`endif

  initial begin
    clr();
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef INSTR_ADDR_CHECK_EN
    test_addr_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
